// File: rtl/seq_pattern_pkg.sv
// Shared state encoding and default sizes for the serial pattern generator.
// SEQ_PATTERN_GEN_PARITY_EN adds the PARITY state (one even-parity bit per frame).
package seq_pattern_pkg;

   localparam int PAT_W_DEF = 6;
   localparam int CNT_W_DEF = 4;
   localparam int GAP_W_DEF = 2;

`ifdef SEQ_PATTERN_GEN_PARITY_EN
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SHIFT  = 3'd1,
      ST_PARITY = 3'd2,
      ST_GAP    = 3'd3,
      ST_DONE   = 3'd4
   } state_t;
`else
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SHIFT  = 3'd1,
      ST_GAP    = 3'd3,
      ST_DONE   = 3'd4
   } state_t;
`endif

endpackage

// File: rtl/seq_piso.sv
// Parallel-load, MSB-first shift register; msb_o is the next bit to transmit.
module seq_piso #(
   parameter int PAT_W = 6
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load_i,
   input  logic             shift_i,
   input  logic [PAT_W-1:0] data_i,
   output logic             msb_o
);

   logic [PAT_W-1:0] sr_q;
   logic [PAT_W-1:0] sr_d;

   always_comb begin
      sr_d = sr_q;
      if (load_i) begin
         sr_d = data_i;
      end else if (shift_i) begin
         sr_d = {sr_q[PAT_W-2:0], 1'b0};
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sr_q <= '0;
      end else begin
         sr_q <= sr_d;
      end
   end

   assign msb_o = sr_q[PAT_W-1];

endmodule

// File: rtl/seq_pattern_gen.sv
// Burst serializer: repeats a latched PAT_W-bit frame MSB first, with optional idle gaps.
// Define SEQ_PATTERN_GEN_PARITY_EN to append an even-parity bit after every frame.
module seq_pattern_gen
   import seq_pattern_pkg::*;
#(
   parameter int PAT_W = PAT_W_DEF,
   parameter int CNT_W = CNT_W_DEF,
   parameter int GAP_W = GAP_W_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [PAT_W-1:0] pattern,
   input  logic [CNT_W-1:0] repeat_cnt,
   input  logic [GAP_W-1:0] gap,
   output logic             x,
   output logic             x_valid,
   output logic             busy,
   output logic             done
);

   localparam int BIT_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
   localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(PAT_W - 1);

   state_t           state_q;
   logic [PAT_W-1:0] pat_q;
   logic [CNT_W-1:0] frame_cnt_q;
   logic [GAP_W-1:0] gap_q;
   logic [GAP_W-1:0] gap_cnt_q;
   logic [BIT_W-1:0] bit_cnt_q;
   logic             x_q;
   logic             x_valid_q;
   logic             busy_q;
   logic             done_q;

   logic             accept;
   logic             frame_end;
   logic             trailer_end;
   logic             more_frames;
   logic             restart;
   logic             piso_load;
   logic             piso_shift;
   logic [PAT_W-1:0] piso_din;
   logic             piso_msb;
   logic             first_bit;

   // frame_cnt_q counts frames still to send after the current one, so a
   // full-scale repeat_cnt never has to be represented as repeat_cnt+1.
   always_comb begin
      accept      = (state_q == ST_IDLE) && start;
      frame_end   = (state_q == ST_SHIFT) && (bit_cnt_q == LAST_BIT);
`ifdef SEQ_PATTERN_GEN_PARITY_EN
      trailer_end = (state_q == ST_PARITY);
`else
      trailer_end = frame_end;
`endif
      more_frames = (frame_cnt_q != '0);
      restart     = (trailer_end && more_frames && (gap_q == '0)) ||
                    ((state_q == ST_GAP) && (gap_cnt_q == '0));
      piso_load   = accept || restart;
      piso_shift  = (state_q == ST_SHIFT) && !frame_end;
      piso_din    = accept ? {pattern[PAT_W-2:0], 1'b0} : {pat_q[PAT_W-2:0], 1'b0};
      first_bit   = accept ? pattern[PAT_W-1] : pat_q[PAT_W-1];
   end

   // The PISO is loaded with the frame already advanced by one bit, because the
   // MSB goes straight into x_q on the loading edge.
   seq_piso #(
      .PAT_W (PAT_W)
   ) u_piso (
      .clk     (clk),
      .reset   (reset),
      .load_i  (piso_load),
      .shift_i (piso_shift),
      .data_i  (piso_din),
      .msb_o   (piso_msb)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         pat_q       <= '0;
         frame_cnt_q <= '0;
         gap_q       <= '0;
         gap_cnt_q   <= '0;
         bit_cnt_q   <= '0;
         x_q         <= 1'b0;
         x_valid_q   <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (accept) begin
            pat_q       <= pattern;
            frame_cnt_q <= repeat_cnt;
            gap_q       <= gap;
            state_q     <= ST_SHIFT;
            bit_cnt_q   <= '0;
            x_q         <= first_bit;
            x_valid_q   <= 1'b1;
            busy_q      <= 1'b1;
         end else if (restart) begin
            frame_cnt_q <= frame_cnt_q - 1'b1;
            state_q     <= ST_SHIFT;
            bit_cnt_q   <= '0;
            x_q         <= first_bit;
            x_valid_q   <= 1'b1;
            busy_q      <= 1'b1;
         end else if (trailer_end) begin
            x_q       <= 1'b0;
            x_valid_q <= 1'b0;
            bit_cnt_q <= '0;
            if (!more_frames) begin
               state_q <= ST_DONE;
               done_q  <= 1'b1;
               busy_q  <= 1'b0;
            end else begin
               state_q   <= ST_GAP;
               gap_cnt_q <= gap_q - 1'b1;
            end
         end else begin
            case (state_q)
               ST_SHIFT: begin
`ifdef SEQ_PATTERN_GEN_PARITY_EN
                  if (frame_end) begin
                     state_q <= ST_PARITY;
                     x_q     <= ^pat_q;
                  end else begin
                     bit_cnt_q <= bit_cnt_q + 1'b1;
                     x_q       <= piso_msb;
                  end
`else
                  bit_cnt_q <= bit_cnt_q + 1'b1;
                  x_q       <= piso_msb;
`endif
               end
               ST_GAP: begin
                  gap_cnt_q <= gap_cnt_q - 1'b1;
               end
               ST_DONE: begin
                  state_q <= ST_IDLE;
               end
               default: begin
               end
            endcase
         end
      end
   end

   assign x       = x_q;
   assign x_valid = x_valid_q;
   assign busy    = busy_q;
   assign done    = done_q;

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Self-checking bench for seq_pattern_gen: table bursts, corner sequences, random bursts.
module tb_seq_pattern_gen;

   localparam int PAT_W = 6;
   localparam int CNT_W = 4;
   localparam int GAP_W = 2;
`ifdef SEQ_PATTERN_GEN_PARITY_EN
   localparam int PAR = 1;
`else
   localparam int PAR = 0;
`endif
   localparam int FB = PAT_W + PAR;

   logic             clk = 1'b0;
   logic             reset;
   logic             start;
   logic [PAT_W-1:0] pattern;
   logic [CNT_W-1:0] repeat_cnt;
   logic [GAP_W-1:0] gap;
   logic             x;
   logic             x_valid;
   logic             busy;
   logic             done;

   seq_pattern_gen #(
      .PAT_W (PAT_W),
      .CNT_W (CNT_W),
      .GAP_W (GAP_W)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .pattern    (pattern),
      .repeat_cnt (repeat_cnt),
      .gap        (gap),
      .x          (x),
      .x_valid    (x_valid),
      .busy       (busy),
      .done       (done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic x;
      logic xv;
      logic busy;
      logic done;
   } obs_t;

   typedef struct {
      logic [PAT_W-1:0] pat;
      int               rep;
      int               gp;
      int               vbits;
      int               busyc;
      int               hits;
   } vec_t;

   obs_t exp_q[$];
   vec_t tbl[6];
   int   vectors = 0;
   int   miscompares = 0;
   int   vbits, busy_cyc, hits, done_cnt, nvalid;
   logic [5:0] win;

   // Expected cycle-by-cycle stream of one burst, starting the cycle after start is taken.
   task automatic build_exp(input logic [PAT_W-1:0] p, input int rep, input int g);
      for (int f = 0; f <= rep; f++) begin
         for (int b = PAT_W - 1; b >= 0; b--) exp_q.push_back('{p[b], 1'b1, 1'b1, 1'b0});
         if (PAR == 1) exp_q.push_back('{^p, 1'b1, 1'b1, 1'b0});
         if (f < rep) for (int k = 0; k < g; k++) exp_q.push_back('{1'b0, 1'b0, 1'b1, 1'b0});
      end
      exp_q.push_back('{1'b0, 1'b0, 1'b0, 1'b1});
      exp_q.push_back('{1'b0, 1'b0, 1'b0, 1'b0});
   endtask

   task automatic clear_stats();
      vbits = 0; busy_cyc = 0; hits = 0; done_cnt = 0; nvalid = 0; win = '0;
   endtask

   task automatic cmp(input string nm, input int got, input int want);
      vectors++;
      if (got !== want) begin
         miscompares++;
         $display("FAIL %s: got %0d want %0d", nm, got, want);
      end
   endtask

   task automatic check(input string nm);
      obs_t e;
      vectors++;
      if (exp_q.size() == 0) begin
         miscompares++;
         $display("FAIL %s: reference stream empty", nm);
         return;
      end
      e = exp_q.pop_front();
      if ({x, x_valid, busy, done} !== {e.x, e.xv, e.busy, e.done}) begin
         miscompares++;
         $display("FAIL %s: got x/xv/busy/done=%b%b%b%b want %b%b%b%b",
                  nm, x, x_valid, busy, done, e.x, e.xv, e.busy, e.done);
      end
      if (x_valid === 1'b1) begin
         win = {win[4:0], x};
         nvalid++;
         vbits++;
         if (nvalid >= 6 && win == 6'b101011) hits++;
      end
      if (busy === 1'b1) busy_cyc++;
      if (done === 1'b1) done_cnt++;
   endtask

   // Caller is at a negedge. mode 0: clean, 1: random start/input noise, 2: start pulse on 3rd SHIFT.
   task automatic run_burst(input logic [PAT_W-1:0] p, input int rep, input int g,
                            input int mode, input string nm);
      int idx;
      clear_stats();
      pattern    = p;
      repeat_cnt = CNT_W'(rep);
      gap        = GAP_W'(g);
      start      = 1'b1;
      build_exp(p, rep, g);
      @(posedge clk);
      #1;
      start = 1'b0;
      idx   = 0;
      while (exp_q.size() > 0) begin
         @(negedge clk);
         if (mode == 1 && exp_q.size() > 2) begin
            start      = 1'($urandom);
            pattern    = PAT_W'($urandom);
            repeat_cnt = CNT_W'($urandom);
            gap        = GAP_W'($urandom);
         end else if (mode == 2) begin
            start = (idx == 2);
         end else begin
            start = 1'b0;
         end
         check(nm);
         idx++;
      end
   endtask

   initial begin
      reset      = 1'b1;
      start      = 1'b0;
      pattern    = '0;
      repeat_cnt = '0;
      gap        = '0;
      #1;
      cmp("reset_outputs", int'({x, x_valid, busy, done}), 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;

      tbl[0] = '{6'b101011, 0,  0, FB,      FB,         1};
      tbl[1] = '{6'b101011, 2,  0, 3 * FB,  3 * FB,     3};
      tbl[2] = '{6'b101011, 1,  3, 2 * FB,  2 * FB + 3, 2};
      tbl[3] = '{6'b101010, 0,  1, FB,      FB,         0};
      tbl[4] = '{6'b111111, 15, 0, 16 * FB, 16 * FB,    0};
      tbl[5] = '{6'b000001, 3,  2, 4 * FB,  4 * FB + 6, 0};

      // First burst starts on the very edge after reset release.
      for (int i = 0; i < 6; i++) begin
         run_burst(tbl[i].pat, tbl[i].rep, tbl[i].gp, 0, $sformatf("tbl%0d", i));
         cmp($sformatf("tbl%0d_vbits", i), vbits, tbl[i].vbits);
         cmp($sformatf("tbl%0d_busy", i), busy_cyc, tbl[i].busyc);
         cmp($sformatf("tbl%0d_hits", i), hits, tbl[i].hits);
         cmp($sformatf("tbl%0d_done", i), done_cnt, 1);
      end

      run_burst(6'b101011, 1, 1, 2, "start_mid_shift");
      cmp("start_mid_shift_done", done_cnt, 1);
      cmp("start_mid_shift_vbits", vbits, 2 * FB);

      // start held high: one IDLE cycle after DONE, then the next burst.
      clear_stats();
      pattern    = 6'b110010;
      repeat_cnt = 4'd0;
      gap        = 2'd0;
      start      = 1'b1;
      build_exp(6'b110010, 0, 0);
      build_exp(6'b110010, 0, 0);
      @(posedge clk);
      #1;
      while (exp_q.size() > 0) begin
         @(negedge clk);
         if (exp_q.size() <= 2) start = 1'b0;
         check("start_held");
      end
      cmp("start_held_done", done_cnt, 2);

      // Reset between edges during the 4th bit.
      clear_stats();
      pattern    = 6'b101011;
      repeat_cnt = 4'd3;
      gap        = 2'd1;
      start      = 1'b1;
      build_exp(6'b101011, 3, 1);
      @(posedge clk);
      #1;
      start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("pre_reset");
      end
      #2;
      reset = 1'b1;
      #1;
      cmp("async_reset_xv", int'(x_valid), 0);
      cmp("async_reset_busy", int'(busy), 0);
      cmp("async_reset_x", int'(x), 0);
      exp_q.delete();
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         cmp($sformatf("post_reset_idle%0d", i), int'({x, x_valid, busy, done}), 0);
      end
      run_burst(6'b011101, 1, 0, 0, "after_reset");
      cmp("after_reset_done", done_cnt, 1);

      // Random bursts with start and input noise while busy.
      for (int t = 0; t < 20; t++) begin
         logic [PAT_W-1:0] rp;
         int rr, rg;
         rp = PAT_W'($urandom);
         rr = $urandom_range(0, 15);
         rg = $urandom_range(0, 3);
         run_burst(rp, rr, rg, 1, $sformatf("rand%0d", t));
         cmp($sformatf("rand%0d_vbits", t), vbits, (rr + 1) * FB);
         cmp($sformatf("rand%0d_busy", t), busy_cyc, (rr + 1) * FB + rr * rg);
         cmp($sformatf("rand%0d_done", t), done_cnt, 1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/seq_pattern_gen.md
SEQ_PATTERN_GEN -- requirements
Module: seq_pattern_gen

Interface
REQ-001 Parameter PAT_W, default 6: pattern length in bits.
REQ-002 Parameter CNT_W, default 4: width of the frame repeat count.
REQ-003 Parameter GAP_W, default 2: width of the inter-frame gap length.
REQ-004 Port clk, input, 1: single clock; all state changes on its rising edge.
REQ-005 Port reset, input, 1: asynchronous, active-high reset.
REQ-006 Port start, input, 1: request to begin a burst; sampled only in IDLE.
REQ-007 Port pattern, input, PAT_W: frame bits, transmitted MSB first.
REQ-008 Port repeat_cnt, input, CNT_W: number of frames in a burst minus one.
REQ-009 Port gap, input, GAP_W: idle cycles inserted between frames.
REQ-010 Port x, output, 1: serial data, compatible with the team's sequence-detector input x.
REQ-011 Port x_valid, output, 1: high when x carries a frame bit.
REQ-012 Port busy, output, 1: high from the first SHIFT cycle through the last frame/parity bit.
REQ-013 Port done, output, 1: one-cycle pulse after the burst ends.

Function
REQ-014 FSM states: IDLE, SHIFT, PARITY (only with the macro), GAP, DONE; state register uses synchronous next-state logic plus async reset.
REQ-015 IDLE, start=1 at edge N: latch pattern, repeat_cnt and gap; SHIFT from N+1.
REQ-016 SHIFT: x = current bit, MSB first; x_valid=1; exactly PAT_W cycles per frame.
REQ-017 All outputs are registered; x=0 whenever x_valid=0.
REQ-018 After the last frame bit (or the parity bit), if frames remain and latched gap>0: GAP for exactly gap cycles with x_valid=0 and busy=1.
REQ-019 If frames remain and latched gap=0: the next frame's MSB follows the previous frame's last bit in the very next cycle (back-to-back frames).
REQ-020 Frames sent per burst = latched repeat_cnt+1; repeat_cnt at maximum gives 2^CNT_W frames, with no counter wrap.
REQ-021 After the final frame: DONE for one cycle (done=1, busy=0, x_valid=0), then IDLE.
REQ-022 start is ignored in SHIFT, PARITY, GAP and DONE; pattern, repeat_cnt and gap changes after latching have no effect on the burst in progress.
REQ-023 start held high continuously: a new burst begins on the first IDLE cycle after DONE.

Reset
REQ-024 Reset asserted at any time, including mid-frame: state=IDLE, x=0, x_valid=0, busy=0, done=0, counters=0, immediately and without waiting for clk.
REQ-025 First start is accepted on the first rising clk edge after reset deasserts.

Configuration
REQ-026 Macro SEQ_PATTERN_GEN_PARITY_EN defined: one PARITY cycle follows each frame; x = XOR of the frame bits (even parity), x_valid=1, busy=1.
REQ-027 Macro undefined: no PARITY state; frames are exactly PAT_W bits.

Structure
REQ-028 Shared package seq_pattern_pkg holds the state enum/encodings and the default values of PAT_W, CNT_W and GAP_W.
REQ-029 One sub-module, seq_piso: a PAT_W-bit parallel-load, MSB-first shift register with load and shift enables; the bit, frame and gap counters are inline.

Verification
REQ-030 pattern=6'b101011, repeat_cnt=0, gap=0, start at N -> x=1,0,1,0,1,1 on N+1..N+6 with x_valid=1; done=1 at N+7; a detector driven by x asserts z on the 6th bit.
REQ-031 pattern=6'b101011, repeat_cnt=2, gap=0 -> 18 contiguous valid bits, busy high for 18 cycles, detector z asserts 3 times, single done pulse.
REQ-032 repeat_cnt=1, gap=3 -> 6 bits, 3 cycles with x_valid=0 and busy=1, 6 bits, done.
REQ-033 start pulsed at the 3rd SHIFT cycle -> ignored; exactly one burst and one done pulse.
REQ-034 reset asserted at the 4th bit between clk edges -> x_valid, busy and x go to 0 at once; after release, IDLE until the next start.
REQ-035 With SEQ_PATTERN_GEN_PARITY_EN: pattern 6'b101011 -> 7 valid bits, 7th=0; with pattern 6'b101010 the 7th bit=1.
